// File: rtl/psram_pkg.sv
// Shared types and default timing for the CellularRAM arbiter slice.
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } psram_state_e;

    typedef enum logic {
        SEL_RD = 1'b0,
        SEL_WR = 1'b1
    } psram_sel_e;

    localparam int DEF_ADDR_W         = 23;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_ACCESS_CYCLES  = 7;
    localparam int DEF_RECOVER_CYCLES = 1;

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester handshakes plus PSRAM pad signals; slave = arbiter, master = requesters/board.
interface psram_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        wr_be;
    logic              wr_ack;

    logic              busy;

    logic [26:1]       MemAdr;
    logic [DATA_W-1:0] mem_dq_o;
    logic [DATA_W-1:0] mem_dq_i;
    logic              mem_dq_oe;
    logic              MemOE;
    logic              MemWR;
    logic              RamCS;
    logic              RamUB;
    logic              RamLB;
    logic              MemAdv;
    logic              RamCRE;
    logic              MemClk;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, mem_dq_i,
        output rd_ack, rd_data, wr_ack, busy, MemAdr, mem_dq_o, mem_dq_oe,
               MemOE, MemWR, RamCS, RamUB, RamLB, MemAdv, RamCRE, MemClk
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, mem_dq_i,
        input  rd_ack, rd_data, wr_ack, busy, MemAdr, mem_dq_o, mem_dq_oe,
               MemOE, MemWR, RamCS, RamUB, RamLB, MemAdv, RamCRE, MemClk
    );

endinterface

// File: rtl/psram_grant.sv
// Port selection between playback read and loader write.
// PSRAM_ARB_FAIR_EN: contested grants alternate via last_grant_q; otherwise read has fixed priority.
module psram_grant
    import psram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rd_req_i,
    input  logic       wr_req_i,
    input  logic       take_i,
    output logic       grant_valid_o,
    output psram_sel_e grant_sel_o
);

`ifdef PSRAM_ARB_FAIR_EN
    psram_sel_e last_grant_q;

    always_comb begin
        grant_valid_o = rd_req_i | wr_req_i;
        grant_sel_o   = SEL_RD;
        if (rd_req_i && wr_req_i) begin
            grant_sel_o = (last_grant_q == SEL_WR) ? SEL_RD : SEL_WR;
        end else if (wr_req_i) begin
            grant_sel_o = SEL_WR;
        end
    end

    // Only contested grants move the fairness pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= SEL_WR;
        end else if (take_i && rd_req_i && wr_req_i) begin
            last_grant_q <= grant_sel_o;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, take_i};

    always_comb begin
        grant_valid_o = rd_req_i | wr_req_i;
        grant_sel_o   = rd_req_i ? SEL_RD : (wr_req_i ? SEL_WR : SEL_RD);
    end
`endif

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter sequencing asynchronous-mode CellularRAM word accesses.
// Optional macro PSRAM_ARB_FAIR_EN selects alternating grants under contention.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input logic            clk,
    input logic            rst,
    psram_arbiter_if.slave bus
);

    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);

    psram_state_e      state_q;
    psram_sel_e        sel_q;
    logic [3:0]        cnt_q;
    logic [26:1]       mem_adr_q;
    logic [DATA_W-1:0] dq_o_q;
    logic              dq_oe_q;
    logic              oe_n_q;
    logic              wr_n_q;
    logic              cs_n_q;
    logic              ub_n_q;
    logic              lb_n_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_ack_q;
    logic              wr_ack_q;
    logic              busy_q;

    logic              gnt_valid;
    psram_sel_e        gnt_sel;
    logic              take;

    assign take = (state_q == ST_IDLE) && gnt_valid;

    psram_grant u_grant (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_req_i      (bus.rd_req),
        .wr_req_i      (bus.wr_req),
        .take_i        (take),
        .grant_valid_o (gnt_valid),
        .grant_sel_o   (gnt_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_RD;
            cnt_q     <= '0;
            mem_adr_q <= '0;
            dq_o_q    <= '0;
            dq_oe_q   <= 1'b0;
            oe_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rd_ack_q <= 1'b0;
            wr_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        sel_q   <= gnt_sel;
                        cs_n_q  <= 1'b0;
                        if (gnt_sel == SEL_WR) begin
                            mem_adr_q          <= 26'(bus.wr_addr);
                            dq_o_q             <= bus.wr_data;
                            dq_oe_q            <= 1'b1;
                            {ub_n_q, lb_n_q}   <= ~bus.wr_be;
                        end else begin
                            mem_adr_q          <= 26'(bus.rd_addr);
                            {ub_n_q, lb_n_q}   <= 2'b00;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    cnt_q   <= ACC_LOAD;
                    oe_n_q  <= (sel_q == SEL_WR);
                    wr_n_q  <= (sel_q != SEL_WR);
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        // All strobes and the bus release on the same edge as CS.
                        state_q <= ST_RECOVER;
                        cnt_q   <= REC_LOAD;
                        cs_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        ub_n_q  <= 1'b1;
                        lb_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (sel_q == SEL_RD) begin
                            rd_data_q <= bus.mem_dq_i;
                            rd_ack_q  <= 1'b1;
                        end else begin
                            wr_ack_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.busy      = busy_q;
    assign bus.MemAdr    = mem_adr_q;
    assign bus.mem_dq_o  = dq_o_q;
    assign bus.mem_dq_oe = dq_oe_q;
    assign bus.MemOE     = oe_n_q;
    assign bus.MemWR     = wr_n_q;
    assign bus.RamCS     = cs_n_q;
    assign bus.RamUB     = ub_n_q;
    assign bus.RamLB     = lb_n_q;
    assign bus.MemAdv    = 1'b0;
    assign bus.RamCRE    = 1'b0;
    assign bus.MemClk    = 1'b0;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: transaction-level reference model, PSRAM pad model,
// directed scenarios and randomized two-port traffic.
module tb_psram_arbiter;

    localparam int AC = 7;
    localparam int RC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psram_arbiter_if #(.ADDR_W(23), .DATA_W(16)) bus ();

    psram_arbiter #(
        .ADDR_W         (23),
        .DATA_W         (16),
        .ACCESS_CYCLES  (AC),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [15:0] dflt(input logic [22:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    logic [15:0] pad_mem [int unsigned];
    logic [15:0] ref_mem [int unsigned];

    function automatic logic [15:0] pad_rd(input logic [22:0] a);
        return pad_mem.exists(32'(a)) ? pad_mem[32'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [22:0] a);
        return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : dflt(a);
    endfunction

    // ---------------- PSRAM pad model ----------------
    logic        p_wr_low = 1'b0;
    logic        p_ub = 1'b1, p_lb = 1'b1, p_oe = 1'b0;
    logic [15:0] p_dq = '0;
    logic [22:0] p_adr = '0;
    logic [15:0] p_word;

    always @(negedge clk) begin
        bus.mem_dq_i = (!bus.RamCS && !bus.MemOE) ? pad_rd(bus.MemAdr[23:1]) : 16'($urandom);
        if (p_wr_low && bus.MemWR && !rst && p_oe) begin
            p_word = pad_rd(p_adr);
            if (!p_ub) p_word[15:8] = p_dq[15:8];
            if (!p_lb) p_word[7:0]  = p_dq[7:0];
            pad_mem[32'(p_adr)] = p_word;
        end
        p_wr_low = !bus.MemWR && !bus.RamCS;
        p_ub  = bus.RamUB;
        p_lb  = bus.RamLB;
        p_oe  = bus.mem_dq_oe;
        p_dq  = bus.mem_dq_o;
        p_adr = bus.MemAdr[23:1];
    end

    // ---------------- Transaction-level reference model ----------------
    // k_m = cycles elapsed since the grant edge; 0 means idle.
    int unsigned k_m     = 0;
    bit          op_wr_m = 1'b0;
    logic [22:0] adr_m   = '0;
    logic [15:0] wd_m    = '0;
    logic [1:0]  be_m    = '0;
    logic [15:0] rd_m    = '0;
    bit          pick_wr;
    logic [15:0] w_m;
`ifdef PSRAM_ARB_FAIR_EN
    bit          last_wr_m = 1'b1;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k_m = 0; adr_m = '0; wd_m = '0; rd_m = '0; op_wr_m = 1'b0;
`ifdef PSRAM_ARB_FAIR_EN
            last_wr_m = 1'b1;
`endif
        end else if (k_m == 0) begin
            if (bus.rd_req || bus.wr_req) begin
                pick_wr = !bus.rd_req;
`ifdef PSRAM_ARB_FAIR_EN
                if (bus.rd_req && bus.wr_req) begin
                    pick_wr   = !last_wr_m;
                    last_wr_m = pick_wr;
                end
`endif
                op_wr_m = pick_wr;
                adr_m   = pick_wr ? bus.wr_addr : bus.rd_addr;
                if (pick_wr) begin
                    wd_m = bus.wr_data;
                    be_m = bus.wr_be;
                end
                k_m = 1;
            end
        end else begin
            if (k_m == AC + 1) begin
                if (op_wr_m) begin
                    w_m = ref_rd(adr_m);
                    if (be_m[1]) w_m[15:8] = wd_m[15:8];
                    if (be_m[0]) w_m[7:0]  = wd_m[7:0];
                    ref_mem[32'(adr_m)] = w_m;
                end else begin
                    rd_m = ref_rd(adr_m);
                end
            end
            k_m = (k_m == AC + 1 + RC) ? 0 : k_m + 1;
        end
    end

    // ---------------- Per-cycle compare + protocol checks ----------------
    bit in_sel, in_acc, in_ack;

    always @(negedge clk) begin
        in_sel = (k_m >= 1) && (k_m <= AC + 1);
        in_acc = (k_m >= 2) && (k_m <= AC + 1);
        in_ack = (k_m == AC + 2);
        check("busy",      32'(bus.busy),      32'(k_m != 0));
        check("RamCS",     32'(bus.RamCS),     32'(!in_sel));
        check("MemOE",     32'(bus.MemOE),     32'(!(in_acc && !op_wr_m)));
        check("MemWR",     32'(bus.MemWR),     32'(!(in_acc && op_wr_m)));
        check("RamUB",     32'(bus.RamUB),     32'(in_sel ? (op_wr_m ? !be_m[1] : 1'b0) : 1'b1));
        check("RamLB",     32'(bus.RamLB),     32'(in_sel ? (op_wr_m ? !be_m[0] : 1'b0) : 1'b1));
        check("mem_dq_oe", 32'(bus.mem_dq_oe), 32'(in_sel && op_wr_m));
        check("rd_ack",    32'(bus.rd_ack),    32'(in_ack && !op_wr_m));
        check("wr_ack",    32'(bus.wr_ack),    32'(in_ack && op_wr_m));
        check("MemAdr",    32'(bus.MemAdr),    32'(adr_m));
        check("mem_dq_o",  32'(bus.mem_dq_o),  32'(wd_m));
        check("rd_data",   32'(bus.rd_data),   32'(rd_m));
        check("oe_wr_exclusive", 32'(!(!bus.MemOE && !bus.MemWR)), 32'd1);
        check("strobe_without_cs",
              32'(bus.RamCS && !(bus.MemOE && bus.MemWR && bus.RamUB && bus.RamLB)), 32'd0);
        check("tieoffs", 32'({bus.MemAdv, bus.RamCRE, bus.MemClk}), 32'd0);
    end

    // ---------------- Stimulus helpers ----------------
    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 300 && bus.busy; i++) @(negedge clk);
        check("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_one(input bit is_wr, input logic [22:0] a, input logic [15:0] d,
                           input logic [1:0] be, output int lat, output int oe_lo,
                           output int wr_lo, output int ub_lo, output int lb_lo,
                           output int dqoe_hi, output logic [15:0] rdat,
                           output logic [2:0] adr_top, output logic [22:0] adr_low);
        wait_idle();
        if (is_wr) begin
            bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be; bus.wr_req = 1'b1;
        end else begin
            bus.rd_addr = a; bus.rd_req = 1'b1;
        end
        lat = -1; oe_lo = 0; wr_lo = 0; ub_lo = 0; lb_lo = 0; dqoe_hi = 0;
        rdat = '0; adr_top = '1; adr_low = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!bus.MemOE) oe_lo++;
            if (!bus.MemWR) wr_lo++;
            if (!bus.RamUB) ub_lo++;
            if (!bus.RamLB) lb_lo++;
            if (bus.mem_dq_oe) dqoe_hi++;
            if (i == 1) begin
                adr_top = bus.MemAdr[26:24];
                adr_low = bus.MemAdr[23:1];
            end
            if (is_wr ? bus.wr_ack : bus.rd_ack) begin
                lat = i;
                rdat = bus.rd_data;
                bus.rd_req = 1'b0;
                bus.wr_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    logic [22:0] pool [8];
    int          lat, oe_lo, wr_lo, ub_lo, lb_lo, dqoe_hi, n_ack, stray_ack;
    logic [15:0] rdat;
    logic [2:0]  adr_top;
    logic [22:0] adr_low;
    logic [7:0]  ord [4];
    string       exp_cont;

    initial begin
        pool[0] = 23'h000123; pool[1] = 23'h7FFFFF; pool[2] = 23'h000000; pool[3] = 23'h400000;
        pool[4] = 23'h012345; pool[5] = 23'h000055; pool[6] = 23'h2AAAAA; pool[7] = 23'h000124;
        pad_mem[32'h123] = 16'hBEEF;
        ref_mem[32'h123] = 16'hBEEF;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        bus.mem_dq_i = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // Single read from a preloaded word.
        run_one(1'b0, 23'h000123, 16'h0, 2'b00, lat, oe_lo, wr_lo, ub_lo, lb_lo, dqoe_hi, rdat, adr_top, adr_low);
        check("rd_latency",  32'(lat),   32'd9);
        check("rd_value",    32'(rdat),  32'hBEEF);
        check("rd_oe_low",   32'(oe_lo), 32'd7);
        check("rd_wr_low",   32'(wr_lo), 32'd0);

        // Single lower-byte write at the top word address.
        run_one(1'b1, 23'h7FFFFF, 16'h1234, 2'b01, lat, oe_lo, wr_lo, ub_lo, lb_lo, dqoe_hi, rdat, adr_top, adr_low);
        check("wr_latency",  32'(lat),     32'd9);
        check("wr_wr_low",   32'(wr_lo),   32'd7);
        check("wr_oe_low",   32'(oe_lo),   32'd0);
        check("wr_lb_low",   32'(lb_lo),   32'd8);
        check("wr_ub_low",   32'(ub_lo),   32'd0);
        check("wr_dqoe_hi",  32'(dqoe_hi), 32'd8);
        check("wr_adr_top",  32'(adr_top), 32'd0);
        check("wr_adr_low",  32'(adr_low), 32'h7FFFFF);
        @(negedge clk);
        check("wr_pad_word", 32'(pad_rd(23'h7FFFFF)), 32'h5A34);

        // Both-byte-disabled write still completes with an ack.
        run_one(1'b1, 23'h000124, 16'hFFFF, 2'b00, lat, oe_lo, wr_lo, ub_lo, lb_lo, dqoe_hi, rdat, adr_top, adr_low);
        check("be00_latency", 32'(lat),   32'd9);
        check("be00_lb_low",  32'(lb_lo), 32'd0);

        // Contention, each requester drops at its own ack.
        wait_idle();
        bus.rd_addr = 23'h000010; bus.rd_req = 1'b1;
        bus.wr_addr = 23'h000020; bus.wr_data = 16'hCAFE; bus.wr_be = 2'b11; bus.wr_req = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 80 && n_ack < 2; i++) begin
            @(negedge clk);
            if (bus.rd_ack) begin ord[n_ack] = "R"; n_ack++; bus.rd_req = 1'b0; end
            if (bus.wr_ack) begin ord[n_ack] = "W"; n_ack++; bus.wr_req = 1'b0; end
        end
        check("contend_acks",  32'(n_ack),  32'd2);
        check("contend_first", 32'(ord[0]), 32'("R"));
        check("contend_second",32'(ord[1]), 32'("W"));

        // Continuous contention for four accesses from a fresh reset.
        wait_idle();
        pulse_reset();
`ifdef PSRAM_ARB_FAIR_EN
        exp_cont = "RWRW";
`else
        exp_cont = "RRRR";
`endif
        bus.rd_addr = 23'h000030; bus.rd_req = 1'b1;
        bus.wr_addr = 23'h000040; bus.wr_data = 16'h0F0F; bus.wr_be = 2'b10; bus.wr_req = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 120 && n_ack < 4; i++) begin
            @(negedge clk);
            if (bus.rd_ack) begin ord[n_ack] = "R"; n_ack++; end
            if (bus.wr_ack) begin ord[n_ack] = "W"; n_ack++; end
        end
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        check("cont_acks", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) check("cont_order", 32'(ord[i]), 32'(exp_cont[i]));

        // Reset during the third ACCESS cycle of a write.
        wait_idle();
        bus.wr_addr = 23'h000055; bus.wr_data = 16'h9999; bus.wr_be = 2'b11; bus.wr_req = 1'b1;
        for (int i = 0; i < 40 && k_m != 4; i++) @(negedge clk);
        check("abort_reached_access3", 32'(k_m), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("abort_cs",     32'(bus.RamCS),     32'd1);
        check("abort_wr",     32'(bus.MemWR),     32'd1);
        check("abort_dqoe",   32'(bus.mem_dq_oe), 32'd0);
        check("abort_wr_ack", 32'(bus.wr_ack),    32'd0);
        bus.wr_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        stray_ack = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.wr_ack) stray_ack++;
        end
        check("abort_no_ack", 32'(stray_ack), 32'd0);
        run_one(1'b0, 23'h000055, 16'h0, 2'b00, lat, oe_lo, wr_lo, ub_lo, lb_lo, dqoe_hi, rdat, adr_top, adr_low);
        check("post_abort_latency", 32'(lat),  32'd9);
        check("post_abort_value",   32'(rdat), 32'hA5F0);

        // Randomized two-port traffic; requests held until acked.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.rd_req) begin
                if (bus.rd_ack) begin
                    if ($urandom_range(0, 1) == 0) bus.rd_req = 1'b0;
                    else bus.rd_addr = pool[$urandom_range(0, 7)];
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.rd_addr = pool[$urandom_range(0, 7)];
                bus.rd_req  = 1'b1;
            end
            if (bus.wr_req) begin
                if (bus.wr_ack) begin
                    if ($urandom_range(0, 1) == 0) bus.wr_req = 1'b0;
                    else begin
                        bus.wr_addr = pool[$urandom_range(0, 7)];
                        bus.wr_data = 16'($urandom);
                        bus.wr_be   = 2'($urandom_range(0, 3));
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.wr_addr = pool[$urandom_range(0, 7)];
                bus.wr_data = 16'($urandom);
                bus.wr_be   = 2'($urandom_range(0, 3));
                bus.wr_req  = 1'b1;
            end
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        wait_idle();
        for (int i = 0; i < 8; i++) check("final_mem", 32'(pad_rd(pool[i])), 32'(ref_rd(pool[i])));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
